// File: rtl/ysyx_22050550_pc_gen.sv
// Fetch-PC generator: holds the fetch PC and picks the next one from trap, return, jump or sequential advance.
// A small circular return-address stack predicts targets for returns.
module ysyx_22050550_pc_gen #(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = 64'h80000000,
    parameter int              INST_BYTES = 4,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           ready,
    input  logic                           id_valid,
    input  logic                           id_jump,
    input  logic                           id_call,
    input  logic                           id_ret,
    input  logic [XLEN-1:0]                id_target,
    input  logic [XLEN-1:0]                id_link,
    input  logic                           trap_valid,
    input  logic [XLEN-1:0]                trap_pc,
    output logic [XLEN-1:0]                pc,
    output logic [XLEN-1:0]                npc,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_hit
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(RAS_DEPTH);
    localparam logic [XLEN-1:0] STEP_C  = XLEN'(INST_BYTES);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   tp_q, tp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];

    logic            ras_we;
    logic [PW-1:0]   ras_waddr;
    logic            id_act, do_call, do_ret, ras_empty;
    logic [XLEN-1:0] tgt_aligned, ret_tgt;

    always_comb begin
        id_act      = id_valid & ~trap_valid;
        do_call     = id_act & id_call;
        do_ret      = id_act & id_ret;
        ras_empty   = (cnt_q == '0);
        tgt_aligned = {id_target[XLEN-1:1], 1'b0};
        ret_tgt     = ras_empty ? tgt_aligned : ras_q[tp_q];
        ras_hit     = do_ret & ~ras_empty;

        if (trap_valid)   pc_d = trap_pc;
        else if (do_ret)  pc_d = ret_tgt;
        else if (id_act && id_jump) pc_d = tgt_aligned;
        else if (ready)   pc_d = pc_q + STEP_C;
        else              pc_d = pc_q;
        npc = pc_d;
    end

    // Coroutine swap (call+ret on a non-empty stack) replaces the top in place.
    always_comb begin
        tp_d      = tp_q;
        cnt_d     = cnt_q;
        ras_we    = 1'b0;
        ras_waddr = tp_q + 1'b1;
        if (do_call && (!do_ret || ras_empty)) begin
            ras_we = 1'b1;
            tp_d   = tp_q + 1'b1;
            cnt_d  = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + 1'b1;
        end else if (do_call && do_ret) begin
            ras_we    = 1'b1;
            ras_waddr = tp_q;
        end else if (do_ret && !ras_empty) begin
            tp_d  = tp_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            tp_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (ras_we) ras_q[ras_waddr] <= id_link;
    end

    assign pc        = pc_q;
    assign ras_count = cnt_q;

endmodule
